// File: rtl/gobou_pkg.sv
// Shared constants and controller state encoding for the gobou FC output path.
package gobou_pkg;

    localparam int DWIDTH = 16;
    localparam int LWIDTH = 10;
    localparam int CORE   = 8;
    localparam int AWIDTH = 12;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/serial_vec.sv
// Parallel-load, shift-out word serializer: loads CORE words on i_we and
// presents word 0 on the next cycle, word 1 on the one after, and so on.
module serial_vec #(
    parameter int DWIDTH = gobou_pkg::DWIDTH,
    parameter int CORE   = gobou_pkg::CORE
) (
    input  logic                         clk,
    input  logic                         xrst,
    input  logic                         i_we,
    input  logic [CORE-1:0][DWIDTH-1:0]  i_data,
    output logic [DWIDTH-1:0]            o_data
);

    logic [CORE-1:0][DWIDTH-1:0] r_buf;

    always_ff @(posedge clk) begin
        if (!xrst) begin
            r_buf <= '0;
        end else if (i_we) begin
            r_buf <= i_data;
        end else begin
            r_buf <= {{DWIDTH{1'b0}}, r_buf[CORE-1:1]};
        end
    end

    assign o_data = r_buf[0];

endmodule

// File: rtl/gobou_serial_ctrl.sv
// Sequences serial_vec loads and the per-word output-memory writes of one layer.
// Optional stall counter output enabled by GOBOU_SERIAL_CTRL_PERF_EN.
module gobou_serial_ctrl #(
    parameter int LWIDTH = gobou_pkg::LWIDTH,
    parameter int CORE   = gobou_pkg::CORE,
    parameter int AWIDTH = gobou_pkg::AWIDTH
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              req,
    input  logic [AWIDTH-1:0] out_base,
    input  logic [LWIDTH-1:0] total_out,
    input  logic              group_valid,
    output logic              group_ready,
    output logic              serial_we,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              busy,
    output logic              done
`ifdef GOBOU_SERIAL_CTRL_PERF_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    import gobou_pkg::*;

    localparam int BW = $clog2(CORE + 1);

    ctrl_state_t       r_state;
    logic [LWIDTH-1:0] r_rem;
    logic [BW-1:0]     r_beats;
    logic [AWIDTH-1:0] r_addr;

    logic              w_last;
    logic              w_more;
    logic              w_accept;
    logic [LWIDTH-1:0] w_rem_grp;
    logic [BW-1:0]     w_beats_new;

    // r_rem counts words not yet written, so on the last beat one word is still in it.
    assign w_last      = (r_state == S_SHIFT) && (r_beats == BW'(1));
    assign w_more      = (r_rem != LWIDTH'(1));
    assign group_ready = (r_state == S_WAIT) || (w_last && w_more);
    assign w_accept    = group_valid && group_ready;
    assign w_rem_grp   = w_last ? (r_rem - LWIDTH'(1)) : r_rem;
    assign w_beats_new = (w_rem_grp >= LWIDTH'(CORE)) ? BW'(CORE) : BW'(w_rem_grp);

    always_ff @(posedge clk) begin
        if (!xrst) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_beats <= '0;
            r_addr  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_addr  <= out_base;
                        r_rem   <= total_out;
                        r_state <= (total_out == '0) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_accept) begin
                        r_beats <= w_beats_new;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_addr <= r_addr + AWIDTH'(1);
                    r_rem  <= r_rem - LWIDTH'(1);
                    if (w_last) begin
                        if (w_accept) begin
                            r_beats <= w_beats_new;
                        end else begin
                            r_beats <= '0;
                            r_state <= w_more ? S_WAIT : S_DONE;
                        end
                    end else begin
                        r_beats <= r_beats - BW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign serial_we = w_accept;
    assign mem_we    = (r_state == S_SHIFT);
    assign mem_addr  = r_addr;
    assign busy      = (r_state == S_WAIT) || (r_state == S_SHIFT);
    assign done      = (r_state == S_DONE);

`ifdef GOBOU_SERIAL_CTRL_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!xrst) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_IDLE) && req) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_WAIT) && !group_valid && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_gobou_serial_ctrl.sv
// Scoreboard bench: gobou_serial_ctrl driving serial_vec; checks write order, addresses and timing.
module tb_gobou_serial_ctrl;
    import gobou_pkg::*;

    typedef struct packed {
        logic [AWIDTH-1:0] a;
        logic [DWIDTH-1:0] d;
    } wr_t;

    logic                        clk = 1'b0;
    logic                        xrst = 1'b0;
    logic                        req = 1'b0;
    logic [AWIDTH-1:0]           out_base = '0;
    logic [LWIDTH-1:0]           total_out = '0;
    logic                        group_valid = 1'b0;
    logic                        group_ready, serial_we, mem_we, busy, done;
    logic [AWIDTH-1:0]           mem_addr;
    logic [CORE-1:0][DWIDTH-1:0] grp = '0;
    logic [DWIDTH-1:0]           sv_out;
`ifdef GOBOU_SERIAL_CTRL_PERF_EN
    logic [31:0]                 stall_cnt;
`endif

    gobou_serial_ctrl dut (
        .clk(clk), .xrst(xrst), .req(req), .out_base(out_base), .total_out(total_out),
        .group_valid(group_valid), .group_ready(group_ready), .serial_we(serial_we),
        .mem_we(mem_we), .mem_addr(mem_addr), .busy(busy), .done(done)
`ifdef GOBOU_SERIAL_CTRL_PERF_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    serial_vec u_sv (.clk(clk), .xrst(xrst), .i_we(serial_we), .i_data(grp), .o_data(sv_out));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0;
    wr_t exp_q[$];
    int  done_q[$];
    int  sw_cyc[$];
    int  we_cnt, sw_cnt, done_cnt, done_cyc, first_we, last_we;
    bit  busy_seen, prev_we, prev_req;
    wr_t e;
    int  k;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [DWIDTH-1:0] word(input int lay, input int g, input int w);
        return DWIDTH'((lay << 12) | (g << 8) | w);
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: pops the scoreboard on every write and checks done placement.
    always @(negedge clk) begin
        if (serial_we === 1'b1) begin
            sw_cnt++;
            sw_cyc.push_back(cyc);
        end
        if (busy === 1'b1) busy_seen = 1'b1;
        if (mem_we === 1'b1) begin
            we_cnt++;
            if (first_we < 0) first_we = cyc;
            last_we = cyc;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write addr=%0h data=%0h", mem_addr, sv_out);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e.a));
                chk("wr_data", 32'(sv_out), 32'(e.d));
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            if (done_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
                k = done_q.pop_front();
                if (k == 1) chk("done_after_last_write", 32'(prev_we), 32'd1);
                else        chk("done_after_req", 32'(prev_req), 32'd1);
                chk("done_pending_writes", 32'(exp_q.size()), 32'd0);
            end
        end
        prev_we  = (mem_we === 1'b1);
        prev_req = (req === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int lay, input int base, input int total);
        for (int i = 0; i < total; i++)
            exp_q.push_back('{a: AWIDTH'(base + i), d: word(lay, i / CORE, i % CORE)});
        done_q.push_back(total == 0 ? 0 : 1);
        we_cnt = 0; sw_cnt = 0; busy_seen = 0; first_we = -1; last_we = -1;
        sw_cyc.delete();
        out_base  = AWIDTH'(base);
        total_out = LWIDTH'(total);
        req = 1'b1;
        tick();
        req = 1'b0;
    endtask

    task automatic send_group(input int lay, input int g, input int gap, input bit keep);
        bit ok = 0;
        if (!keep) group_valid = 1'b0;
        repeat (gap) tick();
        for (int w = 0; w < CORE; w++) grp[w] = word(lay, g, w);
        group_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (group_ready) begin
                ok = 1;
                tick();
                break;
            end
            tick();
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout layer=%0d group=%0d", lay, g);
        end
        if (!keep) group_valid = 1'b0;
    endtask

    task automatic wait_done(input int snap);
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (done_cnt > snap) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL done_timeout snap=%0d", snap);
        end
    endtask

    initial begin
        int snap;
        done_cnt = 0;
        we_cnt = 0; sw_cnt = 0; busy_seen = 0; first_we = -1; last_we = -1;
        repeat (3) tick();
        chk("rst_ready", 32'(group_ready), 0);
        chk("rst_serial_we", 32'(serial_we), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        xrst = 1'b1;
        tick();

        // Two full groups with gaps.
        snap = done_cnt;
        start(1, 'h040, 16);
        send_group(1, 0, 2, 0);
        send_group(1, 1, 3, 0);
        wait_done(snap);
        chk("l1_writes", 32'(we_cnt), 16);
        chk("l1_loads", 32'(sw_cnt), 2);
        tick();
        chk("l1_busy_after_done", 32'(busy), 0);

        // Partial second group.
        snap = done_cnt;
        start(2, 'h040, 10);
        send_group(2, 0, 1, 0);
        send_group(2, 1, 0, 0);
        group_valid = 1'b1;
        for (int i = 0; i < 3; i++) chk("l2_ready_low", 32'(group_ready), 0);
        repeat (2) begin
            chk("l2_ready_low_tail", 32'(group_ready), 0);
            tick();
        end
        group_valid = 1'b0;
        wait_done(snap);
        chk("l2_writes", 32'(we_cnt), 10);
        chk("l2_loads", 32'(sw_cnt), 2);

        // Valid held high, three back-to-back groups.
        snap = done_cnt;
        start(3, 'h080, 24);
        send_group(3, 0, 0, 1);
        send_group(3, 1, 0, 1);
        send_group(3, 2, 0, 1);
        group_valid = 1'b0;
        wait_done(snap);
        chk("l3_loads", 32'(sw_cyc.size()), 3);
        if (sw_cyc.size() == 3) begin
            chk("l3_load_t8", 32'(sw_cyc[1] - sw_cyc[0]), 8);
            chk("l3_load_t16", 32'(sw_cyc[2] - sw_cyc[0]), 16);
            chk("l3_done_t25", 32'(done_cyc - sw_cyc[0]), 25);
            chk("l3_first_we", 32'(first_we - sw_cyc[0]), 1);
        end
        chk("l3_writes", 32'(we_cnt), 24);
        chk("l3_contig", 32'(last_we - first_we), 23);

        // Empty layer.
        snap = done_cnt;
        start(4, 'h123, 0);
        group_valid = 1'b1;
        repeat (3) tick();
        group_valid = 1'b0;
        chk("l4_done_cnt", 32'(done_cnt - snap), 1);
        chk("l4_busy_seen", 32'(busy_seen), 0);
        chk("l4_loads", 32'(sw_cnt), 0);
        chk("l4_writes", 32'(we_cnt), 0);

        // Reset during the 4th shift beat.
        start(5, 'h100, 16);
        send_group(5, 0, 0, 0);
        repeat (3) tick();
        chk("l5_in_shift", 32'(mem_we), 1);
        xrst = 1'b0;
        tick();
        chk("l5_rst_state", 32'(dut.r_state), 32'(S_IDLE));
        chk("l5_rst_ready", 32'(group_ready), 0);
        chk("l5_rst_mem_we", 32'(mem_we), 0);
        chk("l5_rst_addr", 32'(mem_addr), 0);
        chk("l5_rst_busy", 32'(busy), 0);
        chk("l5_rst_done", 32'(done), 0);
        chk("l5_writes_before_rst", 32'(we_cnt), 4);
        xrst = 1'b1;
        exp_q.delete();
        done_q.delete();
        snap = done_cnt;
        repeat (5) tick();
        chk("l5_no_done", 32'(done_cnt - snap), 0);

        // New layer after reset, wrapping addresses, with an ignored mid-layer req.
        snap = done_cnt;
        start(6, 'hFFC, 16);
        send_group(6, 0, 1, 0);
        out_base  = AWIDTH'('h300);
        total_out = LWIDTH'(5);
        req = 1'b1;
        tick();
        req = 1'b0;
        send_group(6, 1, 0, 0);
        wait_done(snap);
        chk("l6_writes", 32'(we_cnt), 16);

`ifdef GOBOU_SERIAL_CTRL_PERF_EN
        snap = done_cnt;
        start(7, 'h010, 8);
        send_group(7, 0, 5, 0);
        wait_done(snap);
        chk("l7_stall_cnt", stall_cnt, 5);
`endif

        repeat (3) tick();
        chk("end_queue_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gobou_serial_ctrl.md
Name: gobou_serial_ctrl

Overview:
- Sequences serial_vec in the gobou fully-connected output path.
- Accepts CORE-wide result groups from the accumulator stage.
- Issues the serial_vec load strobe, then drives one memory write per serialized word at consecutive output addresses.
- Tracks the per-layer output count, so a final partial group writes only the valid words.

Parameters:
- DWIDTH, 16, data word width (passed through to the package only; no data on this block).
- LWIDTH, 10, width of the layer output-count field.
- CORE, 8, words per group; equals serial_vec CORE.
- AWIDTH, 12, output memory address width.

Ports:
- clk  in  1  clock
- xrst  in  1  reset, synchronous, active-low
- req  in  1  layer start pulse; latches out_base and total_out
- out_base  in  AWIDTH  first output address of the layer
- total_out  in  LWIDTH  number of output neurons in the layer
- group_valid  in  1  accumulator group (CORE words) available
- group_ready  out  1  controller can accept a group this cycle
- serial_we  out  1  load strobe to serial_vec
- mem_we  out  1  output memory write enable (data = serial_vec out_data)
- mem_addr  out  AWIDTH  output memory write address
- busy  out  1  layer in progress (req accepted, done not yet pulsed)
- done  out  1  one-cycle layer completion pulse

Behaviour:
- Reset (xrst=0 at a clk edge): state S_IDLE. group_ready, serial_we, mem_we, busy and done = 0. mem_addr = 0. Internal counters cleared.
- Reset mid-layer aborts the layer with no done pulse.
- States: S_IDLE, S_WAIT, S_SHIFT, S_DONE.
- S_IDLE:
  - req=1 latches base and remaining = total_out.
  - Goes to S_WAIT, or to S_DONE if total_out=0.
  - group_valid is ignored.
- S_WAIT: group_ready=1.
- Accept:
  - Accept = group_valid & group_ready.
  - serial_we equals accept combinationally, in the same cycle; serial_vec captures at that edge.
  - beats = min(CORE, remaining).
  - Next state S_SHIFT.
- S_SHIFT:
  - mem_we=1 (registered) for exactly beats consecutive cycles, starting the cycle after accept.
  - mem_addr = base + words already written; incremented after each write.
  - Address wraps modulo 2^AWIDTH.
- Last beat cycle of S_SHIFT:
  - If remaining-beats > 0: group_ready=1. An accept here reloads serial_vec at the same edge the last word is written (no gap, no loss), and the next state is S_SHIFT again.
  - If no accept: go to S_WAIT.
  - If remaining-beats = 0: group_ready=0 and go to S_DONE.
- S_DONE: done=1 for one cycle, busy=0 from the next cycle, return to S_IDLE.
- busy = 1 in S_WAIT and S_SHIFT.
- req outside S_IDLE is ignored.
- group_valid outside a ready cycle is held by the producer; the controller never drops an accepted group.
- Throughput: CORE words per CORE cycles with group_valid held high.
- Latency: accept to first mem_we = 1 cycle; last mem_we to done = 1 cycle.

Optional Feature:
- Macro: GOBOU_SERIAL_CTRL_PERF_EN.
- When defined:
  - Adds output stall_cnt [31:0].
  - Counts cycles in S_WAIT with group_valid=0.
  - Cleared on reset and on req acceptance; saturates at all-ones.
- When undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package gobou_pkg: DWIDTH, LWIDTH, CORE, AWIDTH constants and typedef enum ctrl_state_t {S_IDLE, S_WAIT, S_SHIFT, S_DONE}.
- Sub-module: none required. Beat counter, remaining counter and address counter are inline.
- Bench instantiates gobou_serial_ctrl plus serial_vec to check data order.

Test Plan:
- total_out=16, out_base=0x040, two groups with gaps:
  - Exactly 16 mem_we pulses at addresses 0x040..0x04F.
  - Written data = group0 words 0..7 then group1 words 0..7.
  - done one cycle after the last write.
- total_out=10:
  - Second group writes only 2 words (0x048, 0x049).
  - group_ready stays 0 afterward; done follows.
- group_valid held high, total_out=24:
  - serial_we fires on cycles t, t+8, t+16.
  - mem_we continuous for 24 cycles.
  - done at t+25.
- total_out=0:
  - done one cycle after req.
  - No serial_we, no mem_we.
  - busy never 1.
- xrst=0 during the 4th shift beat:
  - Next cycle all outputs 0 and state S_IDLE.
  - No done pulse.
  - A new req works normally.
- req pulsed while busy with a different out_base:
  - Ignored; addresses continue from the original base.
- With GOBOU_SERIAL_CTRL_PERF_EN, group_valid withheld 5 cycles in S_WAIT:
  - stall_cnt = 5.
